frame_parser: RTL and testbench

- Receives host-to-device command frames byte-by-byte from the UART RX FIFO.
- Checks SOF, command encoding and CRC8, then presents the decoded command, address and write payload to the bridge command executor.
- Is the receive-side counterpart of the response frame builder: the executor's status and echo fields feed that builder.

---
 rtl/bridge_protocol_pkg.sv | 36 +++
 rtl/Crc8_Calculator.sv | 22 ++
 rtl/frame_parser.sv | 174 +++++++++++++++++
 tb/tb_frame_parser.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_protocol_pkg.sv
// Shared host/device bridge protocol constants, CMD field layout and CRC8 helpers.
// Used by both the receive-side frame parser and the response frame builder.
package bridge_protocol_pkg;

  localparam logic [7:0] SOF_HOST_TO_DEVICE = 8'h5A;
  localparam logic [7:0] SOF_DEVICE_TO_HOST = 8'hA5;

  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_CRC_ERR = 8'h01;
  localparam logic [7:0] STATUS_CMD_ERR = 8'h02;
  localparam logic [7:0] STATUS_TIMEOUT = 8'h03;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef struct packed {
    logic       rw;
    logic       inc;
    logic [1:0] size;
    logic [3:0] len;
  } cmd_t;

  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

  // Beats times beat width; largest legal encoding (16 x 4 bytes) is exactly 64.
  function automatic logic [6:0] payload_bytes(input cmd_t cmd);
    return (7'(cmd.len) + 7'd1) << cmd.size;
  endfunction

endpackage

// File: rtl/Crc8_Calculator.sv
// Running CRC8 accumulator (poly 0x07, init 0x00); crc_out includes every byte
// presented with crc_enable up to the previous clock edge.
module Crc8_Calculator
  import bridge_protocol_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       crc_reset,
  input  logic       crc_enable,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  always_ff @(posedge clk) begin
    if (rst || crc_reset) begin
      crc_out <= 8'h00;
    end else if (crc_enable) begin
      crc_out <= crc8_update(crc_out, data_in);
    end
  end

endmodule

// File: rtl/frame_parser.sv
// Host-to-device command frame parser: SOF hunt, CMD/ADDR/DATA capture, CRC8 check.
// Optional inter-byte timeout enabled by defining FRAME_PARSER_TIMEOUT_EN.
module frame_parser
  import bridge_protocol_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int MAX_DATA_BYTES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_fifo_data,
  input  logic       rx_fifo_empty,
  output logic       rx_fifo_rd_en,
  output logic [7:0] cmd_out,
  output logic [31:0] addr_out,
  output logic [7:0] data_out [0:MAX_DATA_BYTES-1],
  output logic [6:0] data_count,
  output logic       frame_valid,
  input  logic       frame_consumed,
  output logic       frame_error,
  output logic [7:0] error_status,
  output logic       parser_busy,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_CMD, ST_ADDR0, ST_ADDR1, ST_ADDR2, ST_ADDR3,
    ST_DATA, ST_CRC, ST_HOLD, ST_ERROR
  } state_t;

  if (MAX_DATA_BYTES != 64) begin : g_bad_depth
    $error("frame_parser: MAX_DATA_BYTES is fixed by the protocol at 64");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("frame_parser: TIMEOUT_CYCLES must be at least 2");
  end

  state_t      state;
  logic [7:0]  cmd_reg;
  logic [31:0] addr_reg;
  logic [6:0]  exp_count;
  logic [6:0]  byte_idx;
  logic [7:0]  data_reg [0:MAX_DATA_BYTES-1];
  logic [7:0]  crc_value;
  cmd_t        rx_cmd;
  logic        accepting;
  logic        in_frame;
  logic        pop;
  logic        timeout;

  // Handshake: a byte moves exactly when rx_fifo_rd_en is high and rx_fifo_empty is low.
  assign accepting     = (state != ST_HOLD) && (state != ST_ERROR);
  assign in_frame      = accepting && (state != ST_IDLE);
  assign rx_fifo_rd_en = !rst && !rx_fifo_empty && accepting;
  assign pop           = rx_fifo_rd_en;
  assign rx_cmd        = cmd_t'(rx_fifo_data);
  assign parser_busy   = (state != ST_IDLE) && (state != ST_HOLD);
  assign state_dbg     = state;

`ifdef FRAME_PARSER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (rst || !in_frame || pop) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign timeout = in_frame && !pop && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  Crc8_Calculator u_crc (
    .clk        (clk),
    .rst        (rst),
    .crc_reset  (state == ST_IDLE),
    .crc_enable (pop && in_frame && (state != ST_CRC)),
    .data_in    (rx_fifo_data),
    .crc_out    (crc_value)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cmd_reg      <= '0;
      addr_reg     <= '0;
      exp_count    <= '0;
      byte_idx     <= '0;
      cmd_out      <= '0;
      addr_out     <= '0;
      data_count   <= '0;
      frame_valid  <= 1'b0;
      frame_error  <= 1'b0;
      error_status <= '0;
      for (int i = 0; i < MAX_DATA_BYTES; i++) begin
        data_reg[i] <= '0;
        data_out[i] <= '0;
      end
    end else begin
      frame_error <= 1'b0;
      if (timeout) begin
        error_status <= STATUS_TIMEOUT;
        frame_error  <= 1'b1;
        state        <= ST_ERROR;
      end else begin
        case (state)
          ST_IDLE: begin
            if (pop && rx_fifo_data == SOF_HOST_TO_DEVICE) state <= ST_CMD;
          end
          ST_CMD: begin
            if (pop) begin
              if (rx_cmd.size == 2'b11) begin
                error_status <= STATUS_CMD_ERR;
                frame_error  <= 1'b1;
                state        <= ST_ERROR;
              end else begin
                cmd_reg   <= rx_fifo_data;
                exp_count <= payload_bytes(rx_cmd);
                state     <= ST_ADDR0;
              end
            end
          end
          ST_ADDR0: if (pop) begin addr_reg[7:0]   <= rx_fifo_data; state <= ST_ADDR1; end
          ST_ADDR1: if (pop) begin addr_reg[15:8]  <= rx_fifo_data; state <= ST_ADDR2; end
          ST_ADDR2: if (pop) begin addr_reg[23:16] <= rx_fifo_data; state <= ST_ADDR3; end
          ST_ADDR3: begin
            if (pop) begin
              addr_reg[31:24] <= rx_fifo_data;
              byte_idx        <= '0;
              state           <= cmd_reg[7] ? ST_CRC : ST_DATA;
            end
          end
          ST_DATA: begin
            if (pop) begin
              data_reg[byte_idx[5:0]] <= rx_fifo_data;
              byte_idx                <= byte_idx + 7'd1;
              if (byte_idx + 7'd1 == exp_count) state <= ST_CRC;
            end
          end
          ST_CRC: begin
            // crc_value already covers the last CMD/ADDR/DATA byte.
            if (pop) begin
              if (rx_fifo_data == crc_value) begin
                cmd_out     <= cmd_reg;
                addr_out    <= addr_reg;
                data_count  <= cmd_reg[7] ? 7'd0 : exp_count;
                data_out    <= data_reg;
                frame_valid <= 1'b1;
                state       <= ST_HOLD;
              end else begin
                error_status <= STATUS_CRC_ERR;
                frame_error  <= 1'b1;
                state        <= ST_ERROR;
              end
            end
          end
          ST_HOLD: begin
            if (frame_consumed) begin
              frame_valid <= 1'b0;
              state       <= ST_IDLE;
            end
          end
          ST_ERROR: state <= ST_IDLE;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_parser.sv
// Directed bench for frame_parser: byte FIFO model, expected-frame scoreboard,
// immediate-assertion checks and a single summary line.
module tb_frame_parser;

  typedef struct packed {
    logic            is_err;
    logic [7:0]      status;
    logic [7:0]      cmd;
    logic [31:0]     addr;
    logic [6:0]      count;
    logic [63:0][7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_fifo_data;
  logic        rx_fifo_empty;
  logic        rx_fifo_rd_en;
  logic [7:0]  cmd_out;
  logic [31:0] addr_out;
  logic [7:0]  data_out [0:63];
  logic [6:0]  data_count;
  logic        frame_valid;
  logic        frame_consumed;
  logic        frame_error;
  logic [7:0]  error_status;
  logic        parser_busy;
  logic [3:0]  state_dbg;

  exp_t        exp_q[$];
  logic [7:0]  fifo_q[$];
  logic        stall_en = 1'b0;
  int          pop_count = 0;
  int          rd_empty_viol = 0;
  int          n_assert = 0;
  int          n_fail = 0;

  frame_parser #(.TIMEOUT_CYCLES(50), .MAX_DATA_BYTES(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_fifo_data   (rx_fifo_data),
    .rx_fifo_empty  (rx_fifo_empty),
    .rx_fifo_rd_en  (rx_fifo_rd_en),
    .cmd_out        (cmd_out),
    .addr_out       (addr_out),
    .data_out       (data_out),
    .data_count     (data_count),
    .frame_valid    (frame_valid),
    .frame_consumed (frame_consumed),
    .frame_error    (frame_error),
    .error_status   (error_status),
    .parser_busy    (parser_busy),
    .state_dbg      (state_dbg)
  );

  // Clock and reset-free clock generation; reset is driven by the main sequence.
  always #5 clk = ~clk;

  // FIFO model: present head byte at negedge+1, decide pop at negedge+4, pop at posedge.
  initial begin
    logic will_pop;
    rx_fifo_empty = 1'b1;
    rx_fifo_data  = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (fifo_q.size() == 0 || (stall_en && $urandom_range(0, 2) == 0)) begin
        rx_fifo_empty = 1'b1;
        rx_fifo_data  = 8'h00;
      end else begin
        rx_fifo_empty = 1'b0;
        rx_fifo_data  = fifo_q[0];
      end
      #3;
      if (rx_fifo_rd_en && rx_fifo_empty) rd_empty_viol++;
      will_pop = rx_fifo_rd_en && !rx_fifo_empty;
      @(posedge clk);
      if (will_pop && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
        pop_count++;
      end
    end
  end

  function automatic logic [7:0] model_crc(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ b[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [63:0][7:0] payload, input logic bad_crc,
                            input logic expect_it, output int nbytes);
    int         n;
    logic [7:0] crc;
    exp_t       e;
    n   = cmd[7] ? 0 : ((int'(cmd[3:0]) + 1) << cmd[5:4]);
    crc = 8'h00;
    fifo_q.push_back(8'h5A);
    fifo_q.push_back(cmd);
    crc = model_crc(crc, cmd);
    for (int k = 0; k < 4; k++) begin
      fifo_q.push_back(addr[8*k +: 8]);
      crc = model_crc(crc, addr[8*k +: 8]);
    end
    for (int k = 0; k < n; k++) begin
      fifo_q.push_back(payload[k]);
      crc = model_crc(crc, payload[k]);
    end
    fifo_q.push_back(bad_crc ? (crc ^ 8'hFF) : crc);
    nbytes = 7 + n;
    if (expect_it) begin
      e        = '0;
      e.is_err = bad_crc;
      e.status = bad_crc ? 8'h01 : 8'h00;
      e.cmd    = cmd;
      e.addr   = addr;
      e.count  = 7'(n);
      e.data   = payload;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_result(input string tag, input int budget, output int cycles);
    exp_t e;
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (cycles < budget && frame_valid !== 1'b1 && frame_error !== 1'b1);
    check({tag, " seen"}, {63'd0, (frame_valid === 1'b1) || (frame_error === 1'b1)}, 64'd1);
    if (exp_q.size() == 0) begin
      check({tag, " exp_q_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, " frame_error"}, {63'd0, frame_error}, {63'd0, e.is_err});
      check({tag, " frame_valid"}, {63'd0, frame_valid}, {63'd0, !e.is_err});
      if (e.is_err) begin
        check({tag, " error_status"}, {56'd0, error_status}, {56'd0, e.status});
        step();
        check({tag, " error_one_cycle"}, {62'd0, frame_error, frame_valid}, 64'd0);
      end else begin
        check({tag, " cmd_out"}, {56'd0, cmd_out}, {56'd0, e.cmd});
        check({tag, " addr_out"}, {32'd0, addr_out}, {32'd0, e.addr});
        check({tag, " data_count"}, {57'd0, data_count}, {57'd0, e.count});
        for (int i = 0; i < int'(e.count); i++) begin
          check($sformatf("%s data_out[%0d]", tag, i), {56'd0, data_out[i]}, {56'd0, e.data[i]});
        end
      end
    end
  endtask

  task automatic consume(input string tag);
    frame_consumed = 1'b1;
    step();
    frame_consumed = 1'b0;
    check({tag, " valid_drop"}, {63'd0, frame_valid}, 64'd0);
  endtask

  initial begin
    logic [63:0][7:0] pl;
    int               nb;
    int               cyc;
    int               target;
    int               guard;
    int               err_seen;
    exp_t             e;

    frame_consumed = 1'b0;
    rst            = 1'b1;
    fifo_q.push_back(8'h11);
    repeat (3) step();
    check("reset rd_en", {63'd0, rx_fifo_rd_en}, 64'd0);
    rst = 1'b0;
    step();
    check("reset flags", {61'd0, frame_valid, frame_error, parser_busy}, 64'd0);
    check("reset cmd_out", {56'd0, cmd_out}, 64'd0);
    check("reset addr_out", {32'd0, addr_out}, 64'd0);
    check("reset data_count", {57'd0, data_count}, 64'd0);
    check("reset error_status", {56'd0, error_status}, 64'd0);
    check("reset state", {60'd0, state_dbg}, 64'd0);
    repeat (2) step();

    // Read frame, FIFO never empty: one pop per cycle straight into HOLD.
    pl = '0;
    send_frame(8'h80, 32'h4000_0010, pl, 1'b0, 1'b1, nb);
    wait_result("read", 100, cyc);
    check("read latency", 64'(cyc), 64'(nb + 1));
    consume("read");

    // Write frame, 2 beats x 4 bytes, then hold back-pressure for 20 cycles.
    for (int i = 0; i < 64; i++) pl[i] = 8'(i + 1);
    send_frame(8'h21, 32'h0000_1000, pl, 1'b0, 1'b1, nb);
    wait_result("write8", 100, cyc);
    check("write8 latency", 64'(cyc), 64'(nb + 1));
    send_frame(8'h80, 32'hDEAD_BEEF, pl, 1'b0, 1'b1, nb);
    for (int i = 0; i < 20; i++) begin
      step();
      check("hold stable", {7'd0, rx_fifo_rd_en, frame_valid, cmd_out, addr_out, data_count, data_out[7]},
            {7'd0, 1'b0, 1'b1, 8'h21, 32'h0000_1000, 7'd8, 8'h08});
    end
    consume("write8");
    wait_result("queued read", 100, cyc);
    consume("queued read");

    // Corrupted CRC: single error pulse, then a good frame still parses.
    send_frame(8'h21, 32'h0000_1000, pl, 1'b1, 1'b1, nb);
    wait_result("bad crc", 100, cyc);
    send_frame(8'h80, 32'h0102_0304, pl, 1'b0, 1'b1, nb);
    wait_result("after bad crc", 100, cyc);
    consume("after bad crc");

    // Garbage then SIZE=11, with frame_consumed asserted outside HOLD.
    frame_consumed = 1'b1;
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    fifo_q.push_back(8'h33);
    fifo_q.push_back(8'h5A);
    fifo_q.push_back(8'h30);
    e        = '0;
    e.is_err = 1'b1;
    e.status = 8'h02;
    exp_q.push_back(e);
    wait_result("bad size", 100, cyc);
    check("bad size latency", 64'(cyc), 64'd6);
    frame_consumed = 1'b0;
    step();
    check("bad size idle", {59'd0, parser_busy, state_dbg}, 64'd0);

    // 64-byte write with random stalls; embedded 0x5A must be treated as data.
    for (int i = 0; i < 64; i++) pl[i] = 8'($urandom_range(0, 255));
    pl[3]    = 8'h5A;
    stall_en = 1'b1;
    send_frame(8'h2F, 32'h8765_4321, pl, 1'b0, 1'b1, nb);
    wait_result("write64", 1000, cyc);
    consume("write64");
    stall_en = 1'b0;

`ifdef FRAME_PARSER_TIMEOUT_EN
    fifo_q.push_back(8'h5A);
    fifo_q.push_back(8'h80);
    e        = '0;
    e.is_err = 1'b1;
    e.status = 8'h03;
    exp_q.push_back(e);
    wait_result("timeout", 300, cyc);
    check("timeout not early", {63'd0, cyc >= 50}, 64'd1);
`endif

    // Reset in the middle of the DATA phase.
    for (int i = 0; i < 64; i++) pl[i] = 8'(8'hC0 ^ i);
    target = pop_count + 20;
    send_frame(8'h2F, 32'h1111_2222, pl, 1'b0, 1'b0, nb);
    guard    = 0;
    err_seen = 0;
    while (pop_count < target && guard < 200) begin
      step();
      guard++;
      if (frame_error === 1'b1) err_seen++;
    end
    check("mid data reached", {63'd0, pop_count >= target}, 64'd1);
    check("mid data state", {60'd0, state_dbg}, 64'd6);
    rst = 1'b1;
    step();
    check("rst rd_en with data", {62'd0, rx_fifo_empty, rx_fifo_rd_en}, 64'd0);
    if (frame_error === 1'b1) err_seen++;
    fifo_q.delete();
    step();
    rst = 1'b0;
    step();
    if (frame_error === 1'b1) err_seen++;
    check("rst no error pulse", 64'(err_seen), 64'd0);
    check("rst outputs", {3'd0, frame_valid, parser_busy, cmd_out, addr_out, data_count, error_status},
          64'd0);
    check("rst data_out", {48'd0, data_out[0], data_out[19]}, 64'd0);
    check("rst state", {60'd0, state_dbg}, 64'd0);

    pl = '0;
    send_frame(8'h80, 32'hCAFE_0001, pl, 1'b0, 1'b1, nb);
    wait_result("post rst read", 100, cyc);
    check("post rst latency", 64'(cyc), 64'(nb + 1));
    consume("post rst read");

    step();
    check("exp_q drained", 64'(exp_q.size()), 64'd0);
    check("rd_en while empty", 64'(rd_empty_viol), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
